// File: rtl/run_ctrl_if.sv
// run_ctrl_if -- button inputs and step-control outputs of the running-light
// controller.
//   key_speed, key_dir, key_pause : active-low raw button pins (asynchronous)
//   step_tick                     : one-cycle pulse, advance pattern one position
//   dir                           : 0 = shift toward MSB, 1 = shift toward LSB
//   speed_lvl                     : current speed level 0..3
//   running                       : 1 = RUN, 0 = PAUSE
// master drives the buttons and observes the outputs; slave is the controller.
interface run_ctrl_if;
  logic       key_speed;
  logic       key_dir;
  logic       key_pause;
  logic       step_tick;
  logic       dir;
  logic [1:0] speed_lvl;
  logic       running;

  modport master (
    output key_speed, key_dir, key_pause,
    input  step_tick, dir, speed_lvl, running
  );

  modport slave (
    input  key_speed, key_dir, key_pause,
    output step_tick, dir, speed_lvl, running
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl -- running-light step controller.
// Three active-low buttons are synchronized and debounced into single press
// events: speed cycles the step rate through 1x/2x/4x/8x, dir flips the shift
// direction, pause toggles a RUN/PAUSE mode FSM. While running, a period
// counter issues a one-cycle step_tick every (STEP_BASE+1) >> speed_lvl cycles.
// Ports:
//   sys_clk : system clock, all state changes on its rising edge
//   sys_rst : asynchronous active-high reset
//   bus     : run_ctrl_if.slave (buttons in; step_tick/dir/speed_lvl/running out)
module run_ctrl #(
  parameter logic [19:0] DEB_MAX   = 20'd999_999,
  parameter logic [24:0] STEP_BASE = 25'd24_999_999
) (
  input  logic     sys_clk,
  input  logic     sys_rst,
  run_ctrl_if.slave bus
);

  localparam int KEYS      = 3;
  localparam int KEY_SPEED = 0;
  localparam int KEY_DIR   = 1;
  localparam int KEY_PAUSE = 2;

  localparam logic [24:0] STEP_PER = STEP_BASE + 25'd1;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } mode_e;

  logic [KEYS-1:0] keys_n;
  logic [KEYS-1:0] meta_q, meta_d;
  logic [KEYS-1:0] sync_q, sync_d;
  logic [19:0]     deb_q [KEYS];
  logic [19:0]     deb_d [KEYS];
  logic [KEYS-1:0] press;

  mode_e       state_q, state_d;
  logic [24:0] tick_cnt_q, tick_cnt_d;
  logic [24:0] per_m1;
  logic        wrap;
  logic        step_tick_q, step_tick_d;
  logic        dir_q, dir_d;
  logic [1:0]  speed_lvl_q, speed_lvl_d;

  assign keys_n = {bus.key_pause, bus.key_dir, bus.key_speed};

  // Synchronizer and debounce: a press fires once, on the edge where the
  // stable-low count reaches DEB_MAX; saturating there blocks repeats until
  // the key is seen released.
  always_comb begin
    meta_d = keys_n;
    sync_d = meta_q;
    press  = '0;
    for (int k = 0; k < KEYS; k++) begin
      deb_d[k] = deb_q[k];
      if (sync_q[k]) begin
        deb_d[k] = '0;
      end else if (deb_q[k] < DEB_MAX) begin
        deb_d[k] = deb_q[k] + 20'd1;
        press[k] = (deb_q[k] == DEB_MAX - 20'd1);
      end
    end
  end

  // Mode FSM: only a pause event moves it, in either direction.
  always_comb begin
    state_d = state_q;
    if (press[KEY_PAUSE]) begin
      case (state_q)
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Period counter and action registers. The wrap decision uses the mode
  // before any same-edge pause event, so a pause landing on a wrap still
  // emits that pulse. A speed event restarts the period and suppresses the
  // pulse even when it coincides with a wrap.
  always_comb begin
    per_m1      = (STEP_PER >> speed_lvl_q) - 25'd1;
    wrap        = (state_q == RUN) && (tick_cnt_q == per_m1);
    tick_cnt_d  = tick_cnt_q;
    step_tick_d = 1'b0;
    dir_d       = dir_q;
    speed_lvl_d = speed_lvl_q;

    if (state_q == RUN) begin
      tick_cnt_d = wrap ? 25'd0 : tick_cnt_q + 25'd1;
    end

    if (press[KEY_SPEED]) begin
      speed_lvl_d = speed_lvl_q + 2'd1;
      tick_cnt_d  = 25'd0;
    end else begin
      step_tick_d = wrap;
    end

    if (press[KEY_DIR]) begin
      dir_d = ~dir_q;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      meta_q      <= '1;
      sync_q      <= '1;
      for (int k = 0; k < KEYS; k++) begin
        deb_q[k] <= '0;
      end
      state_q     <= RUN;
      tick_cnt_q  <= '0;
      step_tick_q <= 1'b0;
      dir_q       <= 1'b0;
      speed_lvl_q <= 2'd0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      for (int k = 0; k < KEYS; k++) begin
        deb_q[k] <= deb_d[k];
      end
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      step_tick_q <= step_tick_d;
      dir_q       <= dir_d;
      speed_lvl_q <= speed_lvl_d;
    end
  end

  assign bus.step_tick = step_tick_q;
  assign bus.dir       = dir_q;
  assign bus.speed_lvl = speed_lvl_q;
  assign bus.running   = (state_q == RUN);

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with DEB_MAX=4, STEP_BASE=15 (base period 16).
// A pin driven low just before edge E0 produces its event on edge E0+5
// (two synchronizer edges, then four stable-low counts).
module tb_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  run_ctrl_if bus ();

  run_ctrl #(
    .DEB_MAX  (20'd4),
    .STEP_BASE(25'd15)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.step_tick !== 1'b1 && n < budget);
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({bus.step_tick, bus.dir, bus.speed_lvl, bus.running} !== 5'b00001)
      $display("FAIL reset_state: got tick/dir/lvl/run=%b want 00001",
               {bus.step_tick, bus.dir, bus.speed_lvl, bus.running});
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(40, n);
      checks++;
      if (n !== 16) $display("FAIL basic_period[%0d]: got %0d cycles want 16", i, n);
      else passed++;
    end
    checks++;
    if ({bus.dir, bus.speed_lvl, bus.running} !== 4'b0001)
      $display("FAIL basic_outputs: got dir/lvl/run=%b want 0001",
               {bus.dir, bus.speed_lvl, bus.running});
    else passed++;
  endtask

  task automatic test_speed();
    int n;
    int m;
    int exp_lvl [3] = '{2, 3, 0};
    // Just after a pulse: event lands on the 6th edge, tick_cnt 5 -> 0.
    bus.key_speed = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.speed_lvl !== 2'd0) $display("FAIL speed_early: got lvl %0d want 0", bus.speed_lvl);
    else passed++;
    tick();
    checks++;
    if (bus.speed_lvl !== 2'd1 || bus.step_tick !== 1'b0)
      $display("FAIL speed_event: got lvl %0d tick %b want 1 0", bus.speed_lvl, bus.step_tick);
    else passed++;
    wait_pulse(40, n);
    checks++;
    if (n !== 8) $display("FAIL speed_first_gap: got %0d cycles want 8", n);
    else passed++;
    for (int i = 0; i < 6; i++) tick();
    bus.key_speed = 1'b1;
    wait_pulse(40, n);
    wait_pulse(40, n);
    checks++;
    if (n !== 8 || bus.speed_lvl !== 2'd1)
      $display("FAIL speed_hold_once: got gap %0d lvl %0d want 8 1", n, bus.speed_lvl);
    else passed++;
    for (int p = 0; p < 3; p++) begin
      bus.key_speed = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      bus.key_speed = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.speed_lvl !== 2'(exp_lvl[p]))
        $display("FAIL speed_level[%0d]: got %0d want %0d", p, bus.speed_lvl, exp_lvl[p]);
      else passed++;
      wait_pulse(40, m);
      wait_pulse(40, m);
      checks++;
      if (m !== (16 >> exp_lvl[p]))
        $display("FAIL speed_gap[%0d]: got %0d want %0d", p, m, 16 >> exp_lvl[p]);
      else passed++;
    end
  endtask

  task automatic test_dir();
    int n;
    bus.key_dir = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.key_dir = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus.dir !== 1'b0) $display("FAIL dir_glitch: got dir %b want 0", bus.dir);
    else passed++;
    wait_pulse(40, n);
    bus.key_dir = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.key_dir = 1'b1;
    wait_pulse(40, n);
    checks++;
    if (bus.dir !== 1'b1 || n + 10 !== 16)
      $display("FAIL dir_press: got dir %b gap %0d want 1 16", bus.dir, n + 10);
    else passed++;
  endtask

  task automatic test_pause();
    int n;
    int cnt;
    bus.key_pause = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.running !== 1'b0 || bus.step_tick !== 1'b0)
      $display("FAIL pause_enter: got run %b tick %b want 0 0", bus.running, bus.step_tick);
    else passed++;
    for (int i = 0; i < 4; i++) tick();
    bus.key_pause = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.step_tick === 1'b1) cnt++;
    end
    checks++;
    if (cnt !== 0 || bus.running !== 1'b0)
      $display("FAIL pause_hold: got %0d pulses run %b want 0 0", cnt, bus.running);
    else passed++;
    bus.key_pause = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    bus.key_pause = 1'b1;
    checks++;
    if (bus.running !== 1'b1) $display("FAIL pause_resume: got run %b want 1", bus.running);
    else passed++;
    wait_pulse(40, n);
    checks++;
    if (n !== 10) $display("FAIL pause_continue: got %0d cycles want 10", n);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int n;
    int cnt;
    for (int i = 0; i < 10; i++) tick();
    bus.key_speed = 1'b0;
    bus.key_pause = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.speed_lvl !== 2'd1 || bus.running !== 1'b0 || bus.step_tick !== 1'b0)
      $display("FAIL simul_wrap: got lvl %0d run %b tick %b want 1 0 0",
               bus.speed_lvl, bus.running, bus.step_tick);
    else passed++;
    bus.key_speed = 1'b1;
    bus.key_pause = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.step_tick === 1'b1) cnt++;
    end
    checks++;
    if (cnt !== 0) $display("FAIL simul_paused: got %0d pulses want 0", cnt);
    else passed++;
    bus.key_pause = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    bus.key_pause = 1'b1;
    wait_pulse(40, n);
    checks++;
    if (n !== 8 || bus.running !== 1'b1)
      $display("FAIL simul_resume: got gap %0d run %b want 8 1", n, bus.running);
    else passed++;
  endtask

  task automatic test_pause_on_wrap();
    tick();
    tick();
    bus.key_pause = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.step_tick !== 1'b0 || bus.running !== 1'b1)
      $display("FAIL pwrap_before: got tick %b run %b want 0 1", bus.step_tick, bus.running);
    else passed++;
    tick();
    checks++;
    if (bus.step_tick !== 1'b1 || bus.running !== 1'b0)
      $display("FAIL pwrap_edge: got tick %b run %b want 1 0", bus.step_tick, bus.running);
    else passed++;
    tick();
    bus.key_pause = 1'b1;
    checks++;
    if (bus.step_tick !== 1'b0) $display("FAIL pwrap_after: got tick %b want 0", bus.step_tick);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    bus.key_pause = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    bus.key_pause = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.key_speed = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.step_tick, bus.dir, bus.speed_lvl, bus.running} !== 5'b00001)
      $display("FAIL reset_mid: got tick/dir/lvl/run=%b want 00001",
               {bus.step_tick, bus.dir, bus.speed_lvl, bus.running});
    else passed++;
    tick();
    tick();
    bus.key_speed = 1'b1;
    rst = 1'b0;
    wait_pulse(40, n);
    checks++;
    if (n !== 16 || bus.speed_lvl !== 2'd0)
      $display("FAIL reset_release: got gap %0d lvl %0d want 16 0", n, bus.speed_lvl);
    else passed++;
  endtask

  initial begin
    bus.key_speed = 1'b1;
    bus.key_dir   = 1'b1;
    bus.key_pause = 1'b1;
    test_reset();
    test_basic();
    test_speed();
    test_dir();
    test_pause();
    test_simultaneous();
    test_pause_on_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
